lc3_sram_ctrl: RTL
==================

Name: lc3_sram_ctrl

Overview:
Memory-access sequencer between the LC-3 control unit/datapath and the off-chip SRAM.
- Accepts single-word read/write requests (the MAR/MDR traffic raised by the control unit's memory states) and drives SRAM strobes for a fixed number of wait cycles.
- Returns a one-cycle Ready pulse that the control unit waits on before leaving its memory states.
- Decodes one memory-mapped I/O address: switches on read, hex-display register on write.

Parameters:
READ_WAIT, 2, cycles SRAM_OE_N is held low per read; legal range 1..15
WRITE_WAIT, 2, cycles SRAM_WE_N is held low per write; legal range 1..15
IO_ADDR, 16'hFFFF, memory-mapped I/O address

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
Rd_Req  in  1  read request, sampled only in IDLE
Wr_Req  in  1  write request, sampled only in IDLE
Addr  in  16  word address (MAR)
Wr_Data  in  16  write data (MDR)
Rd_Data  out  16  read result, registered
Ready  out  1  one-cycle completion pulse
Busy  out  1  high in every state except IDLE
Switches  in  16  board switches, returned on I/O read
Hex_Reg  out  16  hex-display register, loaded on I/O write
SRAM_ADDR  out  20  {4'b0, latched Addr}
SRAM_DQ_In  in  16  SRAM data in
SRAM_DQ_Out  out  16  SRAM data out (latched Wr_Data)
SRAM_DQ_OE  out  1  drive enable for the data bus
SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM strobes

Behaviour:
- Reset (synchronous, wins over everything): state IDLE, counter 0, Rd_Data 0, Hex_Reg 0, latched address and data 0, Ready 0, Busy 0, SRAM_DQ_OE 0, all SRAM_*_N 1. A reset arriving mid-access aborts it: strobes go inactive at that same edge and no Ready is issued.
- States: IDLE, READ, WRITE, WR_HOLD, DONE.
- IDLE, request acceptance:
  - On a clock edge with Rd_Req or Wr_Req high, latch Addr and Wr_Data.
  - If both are high, the write is accepted and the read is dropped.
  - Requests arriving while Busy are ignored; they are not queued.
- SRAM read (latched address != IO_ADDR):
  - IDLE -> READ; counter = READ_WAIT-1.
  - In READ: CE_N, OE_N, UB_N and LB_N are 0. The counter decrements each cycle.
  - At the edge where the counter is 0: Rd_Data <= SRAM_DQ_In; go to DONE.
- SRAM write (latched address != IO_ADDR):
  - IDLE -> WRITE; counter = WRITE_WAIT-1.
  - In WRITE: CE_N, WE_N, UB_N and LB_N are 0; SRAM_DQ_OE is 1; OE_N is 1.
  - Counter 0 -> WR_HOLD. In WR_HOLD: WE_N is 1 while CE_N stays 0 and SRAM_DQ_OE stays 1 (data hold). Then go to DONE.
- I/O read (latched address == IO_ADDR):
  - At the accept edge: Rd_Data <= Switches; IDLE -> DONE.
  - No SRAM strobe is asserted.
- I/O write (latched address == IO_ADDR):
  - At the accept edge: Hex_Reg <= Wr_Data; IDLE -> DONE.
  - No SRAM strobe is asserted.
- DONE: Ready = 1 for exactly this cycle; Rd_Data is stable; next state IDLE. Rd_Data holds its value until the next read completes.
- Latency, counted from the accept edge to the cycle in which Ready is high:
  - SRAM read: READ_WAIT+1 cycles.
  - SRAM write: WRITE_WAIT+2 cycles.
  - I/O access: 1 cycle.
- Back-to-back requests: a request held high through DONE is accepted at the first IDLE edge after DONE. Minimum gap between Ready pulses is 2 cycles for I/O accesses.
- In IDLE and DONE, every SRAM_*_N is 1 and SRAM_DQ_OE is 0.
- SRAM_DQ_OE and a low SRAM_OE_N are never asserted in the same cycle.

Test Plan:
1. Reset, then Rd_Req pulse with Addr=16'h3000 and SRAM model returning 16'hBEEF. Required: OE_N low for exactly 2 cycles, SRAM_ADDR=20'h03000, Ready high 3 cycles after the accept edge, Rd_Data=16'hBEEF, Busy low the following cycle.
2. Wr_Req with Addr=16'h0010 and Wr_Data=16'h1234. Required: WE_N low for 2 cycles with DQ_OE=1 and SRAM_DQ_Out=16'h1234, then 1 hold cycle with WE_N=1 and DQ_OE=1, Ready at cycle 4. A read-back of 16'h0010 then returns 16'h1234.
3. Switches=16'h00A5 and Rd_Req with Addr=16'hFFFF. Required: Ready 1 cycle later, Rd_Data=16'h00A5, CE_N stays 1 throughout. Then Wr_Req to 16'hFFFF with 16'h5A5A: Hex_Reg=16'h5A5A and no SRAM strobes.
4. Rd_Req and Wr_Req high together with Addr=16'h0020. Required: the write sequence runs, memory at 16'h0020 is updated, Rd_Data is unchanged.
5. Rd_Req held high continuously. Required: repeated reads with Ready every 4 cycles (READ_WAIT=2), no strobe overlap. Toggling Wr_Req while Busy has no effect.
6. Reset asserted in the first WRITE cycle. Required: WE_N=1 and DQ_OE=0 at the next edge, no Ready, Hex_Reg=0, Busy=0.

Source files
------------

// File: rtl/lc3_sram_ctrl_if.sv
// Request/response and SRAM bus bundle between the LC-3 control unit and lc3_sram_ctrl.
// The slave modport is the controller; master is the control unit, board and SRAM side.
interface lc3_sram_ctrl_if;
    logic        Rd_Req;
    logic        Wr_Req;
    logic [15:0] Addr;
    logic [15:0] Wr_Data;
    logic [15:0] Rd_Data;
    logic        Ready;
    logic        Busy;
    logic [15:0] Switches;
    logic [15:0] Hex_Reg;
    logic [19:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_In;
    logic [15:0] SRAM_DQ_Out;
    logic        SRAM_DQ_OE;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;
    logic        SRAM_WE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;

    modport slave (
        input  Rd_Req, Wr_Req, Addr, Wr_Data, Switches, SRAM_DQ_In,
        output Rd_Data, Ready, Busy, Hex_Reg, SRAM_ADDR, SRAM_DQ_Out, SRAM_DQ_OE,
        output SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N
    );

    modport master (
        output Rd_Req, Wr_Req, Addr, Wr_Data, Switches, SRAM_DQ_In,
        input  Rd_Data, Ready, Busy, Hex_Reg, SRAM_ADDR, SRAM_DQ_Out, SRAM_DQ_OE,
        input  SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N
    );
endinterface

// File: rtl/lc3_sram_ctrl.sv
// LC-3 memory-access sequencer: single-word SRAM reads/writes with fixed wait states,
// a one-cycle Ready pulse, and one memory-mapped I/O address (switches / hex register).
module lc3_sram_ctrl #(
    parameter int unsigned READ_WAIT  = 2,
    parameter int unsigned WRITE_WAIT = 2,
    parameter logic [15:0] IO_ADDR    = 16'hFFFF
) (
    input  logic          i_clk,
    input  logic          i_reset,
    lc3_sram_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_WR_HOLD,
        S_DONE
    } state_t;

    localparam logic [3:0] RD_INIT = 4'(READ_WAIT - 1);
    localparam logic [3:0] WR_INIT = 4'(WRITE_WAIT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_rd_data;
    logic [15:0] r_hex;
    logic        w_acc_wr;
    logic        w_acc_rd;
    logic        w_is_io;

    // A simultaneous read and write request resolves to the write.
    assign w_acc_wr = bus.Wr_Req;
    assign w_acc_rd = bus.Rd_Req & ~bus.Wr_Req;
    assign w_is_io  = (bus.Addr == IO_ADDR);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_acc_wr)      w_next = w_is_io ? S_DONE : S_WRITE;
                else if (w_acc_rd) w_next = w_is_io ? S_DONE : S_READ;
            end
            S_READ:    if (r_cnt == '0) w_next = S_DONE;
            S_WRITE:   if (r_cnt == '0) w_next = S_WR_HOLD;
            S_WR_HOLD: w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.SRAM_CE_N  = 1'b1;
        bus.SRAM_OE_N  = 1'b1;
        bus.SRAM_WE_N  = 1'b1;
        bus.SRAM_UB_N  = 1'b1;
        bus.SRAM_LB_N  = 1'b1;
        bus.SRAM_DQ_OE = 1'b0;
        case (r_state)
            S_READ: begin
                bus.SRAM_CE_N = 1'b0;
                bus.SRAM_OE_N = 1'b0;
                bus.SRAM_UB_N = 1'b0;
                bus.SRAM_LB_N = 1'b0;
            end
            S_WRITE: begin
                bus.SRAM_CE_N  = 1'b0;
                bus.SRAM_WE_N  = 1'b0;
                bus.SRAM_UB_N  = 1'b0;
                bus.SRAM_LB_N  = 1'b0;
                bus.SRAM_DQ_OE = 1'b1;
            end
            // WE released first; chip select and data stay driven for hold time
            S_WR_HOLD: begin
                bus.SRAM_CE_N  = 1'b0;
                bus.SRAM_UB_N  = 1'b0;
                bus.SRAM_LB_N  = 1'b0;
                bus.SRAM_DQ_OE = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rd_data <= '0;
            r_hex     <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_acc_wr || w_acc_rd) begin
                        r_addr  <= bus.Addr;
                        r_wdata <= bus.Wr_Data;
                        r_cnt   <= w_acc_wr ? WR_INIT : RD_INIT;
                        if (w_acc_wr && w_is_io) r_hex     <= bus.Wr_Data;
                        if (w_acc_rd && w_is_io) r_rd_data <= bus.Switches;
                    end
                end
                S_READ: begin
                    if (r_cnt == '0) r_rd_data <= bus.SRAM_DQ_In;
                    else             r_cnt     <= r_cnt - 4'd1;
                end
                S_WRITE: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.Rd_Data     = r_rd_data;
    assign bus.Hex_Reg     = r_hex;
    assign bus.Ready       = (r_state == S_DONE);
    assign bus.Busy        = (r_state != S_IDLE);
    assign bus.SRAM_ADDR   = {4'b0000, r_addr};
    assign bus.SRAM_DQ_Out = r_wdata;
endmodule
